// File: rtl/x86_muldiv.sv
// rtl/x86_muldiv.sv - iterative MUL/IMUL/DIV/IDIV unit, one radix-2 step per clock
module x86_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               i_size,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   hi,
  output logic               cf_of,
  output logic               exc,
  output logic               busy,
  output logic               done
);

  localparam int W  = WIDTH;
  localparam int W2 = 2 * WIDTH;
  localparam int DW = 2 * WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic           size_q, size_d;
  logic [W2-1:0]  a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [DW-1:0]  acc_q, acc_d;   // product accumulator / partial remainder
  logic [DW-1:0]  sh_q, sh_d;     // multiplicand shifting left / divisor shifting right
  logic [W-1:0]   bits_q, bits_d; // multiplier shifting right / quotient shifting in
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic           cf_q, cf_d, exc_q, exc_d;

  // Operand decode from captured values: size masks, magnitudes and result signs
  logic          wide, is_div, is_signed, sa_m, sa_d, sb, neg_res;
  logic [CW-1:0] n_bits;
  logic [W-1:0]  mask_n, half_n, am_n, b_n, am_abs, b_abs;
  logic [W2-1:0] mask_2n, ad_n, ad_abs, ad_hi;
  always_comb begin
    wide      = size_q && (W != 8);
    is_div    = op_q[1];
    is_signed = op_q[0];
    n_bits    = wide ? CW'(W) : CW'(8);
    mask_n    = wide ? {W{1'b1}} : W'(8'hFF);
    half_n    = wide ? (W'(1) << (W - 1)) : W'(8'h80);
    mask_2n   = wide ? {W2{1'b1}} : W2'(16'hFFFF);
    sa_m      = wide ? a_q[W-1]  : a_q[7];
    sa_d      = wide ? a_q[W2-1] : a_q[15];
    sb        = wide ? b_q[W-1]  : b_q[7];
    am_n      = a_q[W-1:0] & mask_n;
    b_n       = b_q & mask_n;
    ad_n      = a_q & mask_2n;
    // Magnitudes are taken modulo 2^N, so the most negative value maps to 2^(N-1)
    am_abs    = (is_signed && sa_m) ? ((W'(0) - am_n) & mask_n) : am_n;
    b_abs     = (is_signed && sb)   ? ((W'(0) - b_n) & mask_n)  : b_n;
    ad_abs    = (is_signed && sa_d) ? ((W2'(0) - ad_n) & mask_2n) : ad_n;
    ad_hi     = ad_n >> n_bits;
    neg_res   = is_signed && (is_div ? (sa_d ^ sb) : (sa_m ^ sb));
  end

  // Result formatting: sign correction, flag computation and IDIV range check
  logic [W2-1:0] prod_s;
  logic [W-1:0]  mlo, mhi, q_mag, r_mag, q_res, r_res;
  logic          mul_cf, imul_cf, quo_ovf, div_exc;
  always_comb begin
    prod_s  = neg_res ? ((W2'(0) - acc_q[W2-1:0]) & mask_2n) : acc_q[W2-1:0];
    mlo     = prod_s[W-1:0] & mask_n;
    mhi     = W'(prod_s >> n_bits) & mask_n;
    mul_cf  = (mhi != '0);
    imul_cf = (mhi != ((wide ? mlo[W-1] : mlo[7]) ? mask_n : '0));
    q_mag   = bits_q & mask_n;
    r_mag   = acc_q[W-1:0] & mask_n;
    // A leftover remainder >= divisor means the quotient needed more than N bits
    quo_ovf = (acc_q >= DW'(b_abs));
    div_exc = is_signed && (quo_ovf || (neg_res ? (q_mag > half_n) : (q_mag >= half_n)));
    q_res   = neg_res ? ((W'(0) - q_mag) & mask_n) : q_mag;
    r_res   = (is_signed && sa_d) ? ((W'(0) - r_mag) & mask_n) : r_mag;
  end

  // Next-state and datapath update for the operation sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cf_d    = cf_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          op_d    = op;
          size_d  = i_size;
          a_d     = a;
          b_d     = b;
        end
      end
      S_PREP: begin
        if (is_div && ((b_n == '0) || (!is_signed && (ad_hi >= W2'(b_n))))) begin
          state_d = S_DONE;
          exc_d   = 1'b1;
        end else begin
          state_d = S_ITER;
          cnt_d   = n_bits;
          if (is_div) begin
            acc_d  = DW'(ad_abs);
            sh_d   = DW'(b_abs) << (n_bits - CW'(1));
            bits_d = '0;
          end else begin
            acc_d  = '0;
            sh_d   = DW'(am_abs);
            bits_d = b_abs;
          end
        end
      end
      S_ITER: begin
        if (is_div) begin
          if (acc_q >= sh_q) begin
            acc_d  = acc_q - sh_q;
            bits_d = {bits_q[W-2:0], 1'b1};
          end else begin
            bits_d = {bits_q[W-2:0], 1'b0};
          end
          sh_d = sh_q >> 1;
        end else begin
          if (bits_q[0]) acc_d = acc_q + sh_q;
          sh_d   = sh_q << 1;
          bits_d = bits_q >> 1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
        if (is_div) begin
          exc_d = div_exc;
          if (!div_exc) begin
            lo_d = q_res;
            hi_d = r_res;
            cf_d = 1'b0;
          end
        end else begin
          exc_d = 1'b0;
          lo_d  = mlo;
          hi_d  = mhi;
          cf_d  = is_signed ? imul_cf : mul_cf;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      size_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cf_q    <= 1'b0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cf_q    <= cf_d;
      exc_q   <= exc_d;
    end
  end

  assign lo    = lo_q;
  assign hi    = hi_q;
  assign cf_of = cf_q;
  assign exc   = exc_q;
  assign busy  = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_x86_muldiv.sv
// tb/tb_x86_muldiv.sv - vector table, random reference model and corner sequences for x86_muldiv
module tb_x86_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic        i_size;
  logic [31:0] a;
  logic [15:0] b;
  logic [15:0] lo, hi;
  logic        cf_of, exc, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lo, m_hi;
  logic        m_cf;

  typedef struct {
    logic [1:0]  op;
    logic        sz;
    logic [31:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        cf;
    logic        ex;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  x86_muldiv #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .i_size(i_size),
    .a(a), .b(b), .lo(lo), .hi(hi), .cf_of(cf_of), .exc(exc), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: plain integer math on N-bit / 2N-bit values
  function automatic void ref_op(input logic [1:0] o, input logic s, input logic [31:0] av,
                                 input logic [15:0] bv, input logic [15:0] plo, input logic [15:0] phi,
                                 input logic pcf, output logic [15:0] rlo, output logic [15:0] rhi,
                                 output logic rcf, output logic rex, output int rlat);
    int n;
    longint m, m2, half, au, bu, a2, as, bs, a2s, p, q, r;
    n    = s ? 16 : 8;
    m    = (longint'(1) << n) - 1;
    m2   = (longint'(1) << (2 * n)) - 1;
    half = longint'(1) << (n - 1);
    au   = longint'(av) & m;
    bu   = longint'(bv) & m;
    a2   = longint'(av) & m2;
    as   = (au ^ half) - half;
    bs   = (bu ^ half) - half;
    a2s  = (a2 ^ (half << n)) - (half << n);
    rlo = plo; rhi = phi; rcf = pcf; rex = 1'b0; rlat = n + 2;
    if (!o[1]) begin
      p   = o[0] ? as * bs : au * bu;
      rlo = 16'(p & m);
      rhi = 16'((p >> n) & m);
      rcf = o[0] ? ((p < -half) || (p >= half)) : (p > m);
    end else if (bu == 0) begin
      rex = 1'b1; rlat = 1;
    end else if (!o[0]) begin
      if (a2 / bu > m) begin
        rex = 1'b1; rlat = 1;
      end else begin
        rlo = 16'(a2 / bu); rhi = 16'(a2 % bu); rcf = 1'b0;
      end
    end else begin
      q = a2s / bs;
      r = a2s % bs;
      if ((q < -half) || (q >= half)) rex = 1'b1;
      else begin
        rlo = 16'(q & m); rhi = 16'(r & m); rcf = 1'b0;
      end
    end
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o, input logic s, input logic [31:0] av,
                        input logic [15:0] bv, input logic [15:0] elo, input logic [15:0] ehi,
                        input logic ecf, input logic eex, input int elat, input bit spam);
    int cyc;
    bit busy_bad, extra;
    @(negedge clock);
    start = 1'b1; op = o; i_size = s; a = av; b = bv;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); i_size = 1'($urandom); a = $urandom; b = 16'($urandom);
    cyc = 0; busy_bad = 0;
    while (!done && cyc < 100) begin
      if (busy !== 1'b1) busy_bad = 1;
      if (spam) begin start = 1'($urandom); a = $urandom; op = 2'($urandom); end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("%s latency", nm), cyc, elat);
    chk($sformatf("%s busy_during", nm), busy_bad, 0);
    chk($sformatf("%s busy_at_done", nm), busy, 0);
    chk($sformatf("%s exc", nm), exc, eex);
    chk($sformatf("%s lo", nm), lo, elo);
    chk($sformatf("%s hi", nm), hi, ehi);
    chk($sformatf("%s cf_of", nm), cf_of, ecf);
    @(posedge clock); #1;
    chk($sformatf("%s done_single", nm), done, 0);
    if (spam) begin
      extra = 0;
      repeat (6) begin
        @(posedge clock); #1;
        if (busy || done) extra = 1;
      end
      chk($sformatf("%s no_second_op", nm), extra, 0);
    end
  endtask

  task automatic model_run(input string nm, input logic [1:0] o, input logic s,
                           input logic [31:0] av, input logic [15:0] bv, input bit spam);
    logic [15:0] elo, ehi;
    logic ecf, eex;
    int elat;
    ref_op(o, s, av, bv, m_lo, m_hi, m_cf, elo, ehi, ecf, eex, elat);
    run_op(nm, o, s, av, bv, elo, ehi, ecf, eex, elat, spam);
    m_lo = elo; m_hi = ehi; m_cf = ecf;
  endtask

  initial begin
    logic [1:0]  ro;
    logic        rs;
    logic [31:0] ra;
    logic [15:0] rb;
    bit          seen;

    vecs[0]  = '{2'd0, 1'b0, 32'hABCD00FF, 16'h12FF, 16'h0001, 16'h00FE, 1'b1, 1'b0, 10};
    vecs[1]  = '{2'd1, 1'b1, 32'h0000FFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[2]  = '{2'd1, 1'b1, 32'h0000FFFE, 16'h8000, 16'h0000, 16'h0001, 1'b1, 1'b0, 18};
    vecs[3]  = '{2'd2, 1'b1, 32'h00010000, 16'h0002, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
    vecs[4]  = '{2'd2, 1'b1, 32'h00010000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[5]  = '{2'd2, 1'b0, 32'h00001234, 16'hAB00, 16'h8000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[6]  = '{2'd3, 1'b0, 32'hABCDFFF9, 16'h0002, 16'h00FD, 16'h00FF, 1'b0, 1'b0, 10};
    vecs[7]  = '{2'd3, 1'b0, 32'h00008000, 16'h00FF, 16'h00FD, 16'h00FF, 1'b0, 1'b1, 10};
    vecs[8]  = '{2'd0, 1'b0, 32'h00000010, 16'h0010, 16'h0000, 16'h0001, 1'b1, 1'b0, 10};
    vecs[9]  = '{2'd3, 1'b1, 32'h80000000, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b1, 18};
    vecs[10] = '{2'd1, 1'b0, 32'h00000080, 16'h0080, 16'h0000, 16'h0040, 1'b1, 1'b0, 10};
    vecs[11] = '{2'd3, 1'b0, 32'h00000080, 16'h00FF, 16'h0080, 16'h0000, 1'b0, 1'b0, 10};
    vecs[12] = '{2'd3, 1'b0, 32'h0000FF80, 16'h00FF, 16'h0080, 16'h0000, 1'b0, 1'b1, 10};
    vecs[13] = '{2'd0, 1'b1, 32'h0000FFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 18};
    vecs[14] = '{2'd2, 1'b0, 32'h0000FEFF, 16'h00FF, 16'h00FF, 16'h00FE, 1'b0, 1'b0, 10};

    reset = 1'b1; start = 1'b0; op = 2'd0; i_size = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset lo", lo, 0);
    chk("reset hi", hi, 0);
    chk("reset cf_of", cf_of, 0);
    chk("reset exc", exc, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sz, vecs[i].a, vecs[i].b,
             vecs[i].lo, vecs[i].hi, vecs[i].cf, vecs[i].ex, vecs[i].lat, 1'b0);
    m_lo = vecs[14].lo; m_hi = vecs[14].hi; m_cf = vecs[14].cf;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rs = 1'($urandom);
      ra = $urandom;
      rb = 16'($urandom);
      if (ro[1] && $urandom_range(0, 1) == 1) rb = rb | (rs ? 16'h8000 : 16'h0080);
      model_run($sformatf("rnd%0d", i), ro, rs, ra, rb, 1'b0);
    end

    model_run("spam", 2'd0, 1'b1, 32'h00001234, 16'h5678, 1'b1);

    // Reset during ITER cycle 5 of a 16-bit divide
    @(negedge clock);
    start = 1'b1; op = 2'd2; i_size = 1'b1; a = 32'h00123456; b = 16'h0100;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    chk("midreset busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset done", done, 0);
    chk("midreset lo", lo, 0);
    chk("midreset hi", hi, 0);
    chk("midreset cf_of", cf_of, 0);
    chk("midreset exc", exc, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1;
    end
    chk("midreset no_done", seen, 0);
    m_lo = '0; m_hi = '0; m_cf = 1'b0;
    model_run("post_reset", 2'd0, 1'b0, 32'h00000003, 16'h0005, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
